// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/funct
// values, ALU control codes and datapath select encodings.
// Imported by mc_controller and alu_decoder.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_IEX    = 4'd8,
        S_ZEX    = 4'd9,
        S_IWB    = 4'd10,
        S_BEQ    = 4'd11,
        S_BNE    = 4'd12,
        S_JMP    = 4'd13
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LD    = 6'b110111;
    localparam logic [5:0] OP_SD    = 6'b111111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_DADDI = 6'b011000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_DADD = 6'b101100;
    localparam logic [5:0] FN_DSUB = 6'b101110;

    // ALU control codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_DADD = 4'b1010;
    localparam logic [3:0] ALU_DSUB = 4'b1110;

    // alusrcb encodings
    localparam logic [2:0] SRCB_B       = 3'd0;
    localparam logic [2:0] SRCB_FOUR    = 3'd1;
    localparam logic [2:0] SRCB_SIMM    = 3'd2;
    localparam logic [2:0] SRCB_SIMM_SH = 3'd3;
    localparam logic [2:0] SRCB_ZIMM    = 3'd4;

    // pcsrc encodings
    localparam logic [1:0] PC_ALURES = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    // ltype encodings
    localparam logic [1:0] LT_WORD = 2'd0;
    localparam logic [1:0] LT_LBU  = 2'd1;
    localparam logic [1:0] LT_LB   = 2'd2;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decode: picks the ALU operation from the current state, op and funct.
// Purely combinational, zero latency; no flow control.
// Ports: state (current FSM state), op, funct in; alucontrol out.
module alu_decoder
    import mc_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output logic [3:0]  alucontrol
);

    always_comb begin
        alucontrol = ALU_AND;
        case (state)
            S_FETCH:           alucontrol = ALU_ADD;
            S_DECODE, S_MEMADR: alucontrol = ALU_DADD;
            S_REX: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    FN_DADD: alucontrol = ALU_DADD;
                    FN_DSUB: alucontrol = ALU_DSUB;
                    // unknown funct still executes and writes back, as an add
                    default: alucontrol = ALU_ADD;
                endcase
            end
            S_IEX: begin
                case (op)
                    OP_DADDI: alucontrol = ALU_DADD;
                    OP_SLTI:  alucontrol = ALU_SLT;
                    default:  alucontrol = ALU_ADD;
                endcase
            end
            S_ZEX:             alucontrol = (op == OP_ORI) ? ALU_OR : ALU_AND;
            S_BEQ, S_BNE:      alucontrol = ALU_SUB;
            default:           alucontrol = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM driving the 64-bit datapath enables, mux selects and memwrite.
// Moore outputs (pcen also sees zero); 2..5 cycles per instruction; no backpressure.
// Ports: clk, reset (async high), op/funct/zero in; pcen..ltype controls and state_o out.
module mc_controller
    import mc_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pcen,
    output logic        irwrite,
    output logic        regwrite,
    output logic        memwrite,
    output logic        dtype,
    output logic        iord,
    output logic        memtoreg,
    output logic        regdst,
    output logic        alusrca,
    output logic [2:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [3:0]  alucontrol,
    output logic [1:0]  ltype,
    output logic [3:0]  state_o
);

    state_t      state_q, state_d;
    // Memory access kind, captured at DECODE and held through the access.
    logic        mem_store_q, mem_store_d;
    logic        mem_dword_q, mem_dword_d;
    logic [1:0]  mem_ltype_q, mem_ltype_d;

    logic pcwrite, branch, bne_br;
    logic irwrite_raw, regwrite_raw, memwrite_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            mem_store_q <= 1'b0;
            mem_dword_q <= 1'b0;
            mem_ltype_q <= LT_WORD;
        end else begin
            state_q     <= state_d;
            mem_store_q <= mem_store_d;
            mem_dword_q <= mem_dword_d;
            mem_ltype_q <= mem_ltype_d;
        end
    end

    always_comb begin
        state_d      = S_FETCH;
        mem_store_d  = mem_store_q;
        mem_dword_d  = mem_dword_q;
        mem_ltype_d  = mem_ltype_q;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        bne_br       = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        dtype        = 1'b0;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = SRCB_B;
        pcsrc        = PC_ALURES;
        ltype        = LT_WORD;

        case (state_q)
            S_FETCH: begin
                irwrite_raw = 1'b1;
                alusrcb     = SRCB_FOUR;
                pcwrite     = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                alusrcb     = SRCB_SIMM_SH;
                mem_store_d = (op == OP_SW) || (op == OP_SD);
                mem_dword_d = (op == OP_LD) || (op == OP_SD);
                mem_ltype_d = (op == OP_LB)  ? LT_LB  :
                              (op == OP_LBU) ? LT_LBU : LT_WORD;
                case (op)
                    OP_LW, OP_SW, OP_LD, OP_SD, OP_LB, OP_LBU: state_d = S_MEMADR;
                    OP_R:                                      state_d = S_REX;
                    OP_BEQ:                                    state_d = S_BEQ;
                    OP_BNE:                                    state_d = S_BNE;
                    OP_ADDI, OP_DADDI, OP_SLTI:                state_d = S_IEX;
                    OP_ANDI, OP_ORI:                           state_d = S_ZEX;
                    OP_J:                                      state_d = S_JMP;
                    default:                                   state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_SIMM;
                state_d = mem_store_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                dtype   = mem_dword_q;
                ltype   = mem_ltype_q;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                dtype        = mem_dword_q;
                ltype        = mem_ltype_q;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                dtype        = mem_dword_q;
            end
            S_REX: begin
                alusrca = 1'b1;
                state_d = S_RWB;
            end
            S_RWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_IEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_SIMM;
                state_d = S_IWB;
            end
            S_ZEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_ZIMM;
                state_d = S_IWB;
            end
            S_IWB: regwrite_raw = 1'b1;
            S_BEQ: begin
                alusrca = 1'b1;
                pcsrc   = PC_ALUOUT;
                branch  = 1'b1;
            end
            S_BNE: begin
                alusrca = 1'b1;
                pcsrc   = PC_ALUOUT;
                bne_br  = 1'b1;
            end
            S_JMP: begin
                pcsrc   = PC_JUMP;
                pcwrite = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .state      (state_q),
        .op         (op),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    // Enables are gated by reset directly so no write can slip out in the
    // cycle reset rises, even though state_q already reads FETCH.
    assign pcen     = ~reset & (pcwrite | (branch & zero) | (bne_br & ~zero));
    assign irwrite  = ~reset & irwrite_raw;
    assign regwrite = ~reset & regwrite_raw;
    assign memwrite = ~reset & memwrite_raw;
    assign state_o  = state_q;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pcen, irwrite, regwrite, memwrite, dtype, iord, memtoreg, regdst, alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc, ltype;
    logic [3:0] alucontrol, state_o;

    int n_cmp  = 0;
    int n_fail = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .dtype(dtype), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .ltype(ltype), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, irwrite, regwrite, memwrite, dtype, iord, memtoreg, regdst, alusrca;
        logic [2:0] alusrcb;
        logic [1:0] pcsrc;
        logic [3:0] aluc;
        logic [1:0] ltype;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         zmode;   // 0/1 fixed zero, 2 random per cycle
        int         cycles;  // instruction length from FETCH back to FETCH
        string      name;
    } vec_t;

    function automatic out_t sample_dut();
        out_t a;
        a = '{st: state_o, pcen: pcen, irwrite: irwrite, regwrite: regwrite, memwrite: memwrite,
              dtype: dtype, iord: iord, memtoreg: memtoreg, regdst: regdst, alusrca: alusrca,
              alusrcb: alusrcb, pcsrc: pcsrc, aluc: alucontrol, ltype: ltype};
        return a;
    endfunction

    task automatic check_out(input string name, input int cyc, input out_t exp);
        out_t act;
        act = sample_dut();
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, required %h (state got %0d req %0d)",
                     name, cyc, act, exp, act.st, exp.st);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_load(input logic [5:0] o);
        return o == 6'b100011 || o == 6'b110111 || o == 6'b100000 || o == 6'b100100;
    endfunction
    function automatic bit m_store(input logic [5:0] o);
        return o == 6'b101011 || o == 6'b111111;
    endfunction
    function automatic logic m_dword(input logic [5:0] o);
        return (o == 6'b110111 || o == 6'b111111) ? 1'b1 : 1'b0;
    endfunction
    function automatic logic [1:0] m_ltype(input logic [5:0] o);
        if (o == 6'b100000) return 2'd2;
        if (o == 6'b100100) return 2'd1;
        return 2'd0;
    endfunction
    function automatic logic [3:0] m_rfunc(input logic [5:0] f);
        case (f)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b101100: return 4'b1010;
            6'b101110: return 4'b1110;
            default:   return 4'b0010;
        endcase
    endfunction

    // State walk of one instruction as the sequence of steps it takes.
    task automatic m_seq(input logic [5:0] o, output state_t s[$]);
        s = {S_FETCH, S_DECODE};
        if (m_load(o))                  s = {s, S_MEMADR, S_MEMRD, S_MEMWB};
        else if (m_store(o))            s = {s, S_MEMADR, S_MEMWR};
        else if (o == 6'b000000)        s = {s, S_REX, S_RWB};
        else if (o == 6'b001000 || o == 6'b011000 || o == 6'b001010) s = {s, S_IEX, S_IWB};
        else if (o == 6'b001100 || o == 6'b001101) s = {s, S_ZEX, S_IWB};
        else if (o == 6'b000100)        s.push_back(S_BEQ);
        else if (o == 6'b000101)        s.push_back(S_BNE);
        else if (o == 6'b000010)        s.push_back(S_JMP);
    endtask

    function automatic out_t m_out(input state_t s, input logic [5:0] o, input logic [5:0] f,
                                   input logic z);
        out_t e;
        e = '0;
        e.st = s;
        case (s)
            S_FETCH:  begin e.irwrite = 1; e.alusrcb = 1; e.aluc = 4'b0010; e.pcen = 1; end
            S_DECODE: begin e.alusrcb = 3; e.aluc = 4'b1010; end
            S_MEMADR: begin e.alusrca = 1; e.alusrcb = 2; e.aluc = 4'b1010; end
            S_MEMRD:  begin e.iord = 1; e.dtype = m_dword(o); e.ltype = m_ltype(o); end
            S_MEMWB:  begin e.memtoreg = 1; e.regwrite = 1; e.dtype = m_dword(o); e.ltype = m_ltype(o); end
            S_MEMWR:  begin e.iord = 1; e.memwrite = 1; e.dtype = m_dword(o); end
            S_REX:    begin e.alusrca = 1; e.aluc = m_rfunc(f); end
            S_RWB:    begin e.regdst = 1; e.regwrite = 1; end
            S_IEX:    begin
                e.alusrca = 1; e.alusrcb = 2;
                e.aluc = (o == 6'b011000) ? 4'b1010 : (o == 6'b001010) ? 4'b0111 : 4'b0010;
            end
            S_ZEX:    begin e.alusrca = 1; e.alusrcb = 4; e.aluc = (o == 6'b001101) ? 4'b0001 : 4'b0000; end
            S_IWB:    e.regwrite = 1;
            S_BEQ:    begin e.alusrca = 1; e.aluc = 4'b0110; e.pcsrc = 1; e.pcen = z; end
            S_BNE:    begin e.alusrca = 1; e.aluc = 4'b0110; e.pcsrc = 1; e.pcen = ~z; end
            S_JMP:    begin e.pcsrc = 2; e.pcen = 1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    // Runs one instruction starting just after the edge that entered FETCH.
    // Compares every cycle against the model and checks the cycle count.
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input int zmode, input int exp_cycles);
        state_t seq[$];
        state_t es;
        int cyc;
        int want;
        bit done;
        m_seq(o, seq);
        op = o;
        funct = f;
        cyc = 0;
        done = 0;
        while (!done) begin
            zero = (zmode == 2) ? 1'($urandom_range(1)) : 1'(zmode);
            @(negedge clk);
            es = (cyc < seq.size()) ? seq[cyc] : S_FETCH;
            check_out(name, cyc, m_out(es, o, f, zero));
            @(posedge clk);
            #1;
            cyc++;
            if (state_o == S_FETCH) done = 1;
            else if (cyc >= 12) begin
                n_cmp++; n_fail++;
                $display("FAIL %s timeout: no return to FETCH after %0d cycles", name, cyc);
                done = 1;
            end
        end
        want = (exp_cycles >= 0) ? exp_cycles : seq.size();
        n_cmp++;
        if (cyc != want) begin
            n_fail++;
            $display("FAIL %s cycle count: got %0d, required %0d", name, cyc, want);
        end
    endtask

    vec_t vecs[$];
    logic [5:0] legal_ops[15] = '{6'b000000, 6'b100011, 6'b101011, 6'b110111, 6'b111111,
                                  6'b100000, 6'b100100, 6'b000100, 6'b000101, 6'b001000,
                                  6'b011000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};
    logic [5:0] functs[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b101010, 6'b101100, 6'b101110};

    initial begin
        out_t er;
        vecs = '{
            '{6'b100000, 6'b000000, 0, 5, "lb"},
            '{6'b100100, 6'b000000, 0, 5, "lbu"},
            '{6'b100011, 6'b000000, 1, 5, "lw"},
            '{6'b110111, 6'b000000, 0, 5, "ld"},
            '{6'b101011, 6'b000000, 0, 4, "sw"},
            '{6'b111111, 6'b000000, 1, 4, "sd"},
            '{6'b000100, 6'b000000, 1, 3, "beq_taken"},
            '{6'b000100, 6'b000000, 0, 3, "beq_not_taken"},
            '{6'b000101, 6'b000000, 1, 3, "bne_not_taken"},
            '{6'b000101, 6'b000000, 0, 3, "bne_taken"},
            '{6'b000000, 6'b101110, 0, 4, "r_dsub"},
            '{6'b000000, 6'b100000, 0, 4, "r_add"},
            '{6'b000000, 6'b111111, 0, 4, "r_unknown_funct"},
            '{6'b001000, 6'b000000, 0, 4, "addi"},
            '{6'b011000, 6'b000000, 0, 4, "daddi"},
            '{6'b001010, 6'b000000, 0, 4, "slti"},
            '{6'b001100, 6'b000000, 0, 4, "andi"},
            '{6'b001101, 6'b000000, 0, 4, "ori"},
            '{6'b000010, 6'b000000, 1, 3, "j"},
            '{6'b111000, 6'b000000, 0, 2, "illegal"}
        };

        reset = 1'b1;
        op = 6'b111111;   // a store in IR must not leak a write during reset
        funct = 6'b0;
        zero = 1'b1;

        // Reset held for 3 cycles: FETCH selects, every enable low.
        er = m_out(S_FETCH, 6'b0, 6'b0, 1'b0);
        er.pcen = 0;
        er.irwrite = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_out("reset_hold", i, er);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_bit("post_reset_irwrite", irwrite, 1'b1);
        check_bit("post_reset_pcen", pcen, 1'b1);

        foreach (vecs[i])
            run_instr(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].zmode, vecs[i].cycles);

        // Reset rising in the middle of the sd write cycle.
        op = 6'b111111;
        funct = 6'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_bit("sd_memwr_before_reset", memwrite, 1'b1);
        reset = 1'b1;
        #1;
        check_bit("reset_mid_memwr_memwrite", memwrite, 1'b0);
        n_cmp++;
        if (state_o !== 4'(S_FETCH)) begin
            n_fail++;
            $display("FAIL reset_mid_memwr_state: got %0d, required %0d", state_o, S_FETCH);
        end
        check_bit("reset_mid_memwr_pcen", pcen, 1'b0);
        check_bit("reset_mid_memwr_irwrite", irwrite, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Randomized instruction stream.
        for (int k = 0; k < 200; k++) begin
            logic [5:0] o, f;
            o = ($urandom_range(9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(14)];
            f = ($urandom_range(7) == 0) ? 6'($urandom) : functs[$urandom_range(6)];
            run_instr("random", o, f, 2, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
